// File: rtl/freq_pkg.sv
// Shared constants, digit type and saturation helper for the frequency meter.
package freq_pkg;
  localparam int BCD_W          = 4;
  localparam int DIGITS_DEFAULT = 4;
  localparam int MAX_DIGITS     = 32;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  // True when the low ndig digits of cnt are all 9 (count at top of range).
  function automatic logic all_nines(input logic [BCD_W*MAX_DIGITS-1:0] cnt,
                                     input int ndig);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < ndig && cnt[i*BCD_W +: BCD_W] != BCD_MAX) r = 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: wraps 9->0, freezes while saturated.
module bcd_digit
  import freq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr_n,
  input  logic inc_in,
  input  logic sat,
  output bcd_t q,
  output logic carry_out
);

  // Ripple increment request to the next decade when this one rolls over.
  assign carry_out = inc_in & (q == BCD_MAX);

  // Clear has priority; saturation blocks the all-nines -> all-zeros wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                q <= '0;
    else if (!clr_n)           q <= '0;
    else if (inc_in && !sat)   q <= (q == BCD_MAX) ? '0 : q + 4'd1;
  end

  // Values 10-15 can never be reached; seeing one means broken logic.
  always_ff @(posedge clk) begin
    if (reset) assert (q <= BCD_MAX);
  end

endmodule

// File: rtl/freq_counter_latch.sv
// Gate-window BCD edge counter with display latch and sticky overflow.
module freq_counter_latch
  import freq_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sig_in,
  input  logic                  clr_n,
  input  logic                  enable,
  input  logic                  latch,
  output logic [BCD_W*DIGITS-1:0] freq_bcd,
  output logic                  ovf,
  output logic                  valid
);

  localparam int W = BCD_W*DIGITS;

  logic [SYNC_STAGES-1:0]        sync_q;
  logic                          s_prev;
  logic                          edge_det;
  logic [DIGITS-1:0][BCD_W-1:0]  count;
  logic [DIGITS:0]               inc;
  logic                          sat;
  logic                          ovf_int;
  logic                          latch_d;
  logic                          latch_rise;

  // Synchroniser chain for the asynchronous input plus one history flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~s_prev;
  assign inc[0]   = enable & edge_det;
  assign sat      = all_nines({{(BCD_W*MAX_DIGITS-W){1'b0}}, count}, DIGITS);

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .clk       (clk),
        .reset     (reset),
        .clr_n     (clr_n),
        .inc_in    (inc[g]),
        .sat       (sat),
        .q         (count[g]),
        .carry_out (inc[g+1])
      );
    end
  endgenerate

  // Carry out of the top decade means an increment past all nines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ovf_int <= 1'b0;
    else if (!clr_n)    ovf_int <= 1'b0;
    else if (inc[DIGITS]) ovf_int <= 1'b1;
  end

  // Latch history resets high so the FSM's idle-high latch is not a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) latch_d <= 1'b1;
    else        latch_d <= latch;
  end

  assign latch_rise = latch & ~latch_d;

  // Display register: capture pre-update count on a latch rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq_bcd <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= latch_rise;
      if (latch_rise) begin
        freq_bcd <= count;
        ovf      <= ovf_int;
      end
    end
  end

endmodule

// File: tb/tb_freq_counter_latch.sv
// Randomised edge streams against an integer-count reference model.
module tb_freq_counter_latch;
  import freq_pkg::*;

  localparam int DIGITS = 4;
  localparam int SYNC   = 2;
  localparam int MAXCNT = 9999;

  logic clk = 1'b0, reset = 1'b0, sig_in = 1'b0, clr_n = 1'b1;
  logic enable = 1'b0, latch = 1'b1;
  logic [15:0] freq_bcd;
  logic ovf, valid;

  int checks = 0, failures = 0;

  // reference model state
  int   m_cnt;
  bit   m_ovf_int, m_ovf, m_valid, m_latch_d;
  bit [15:0] m_bcd;
  bit   h[0:SYNC];

  freq_counter_latch #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .clr_n(clr_n),
    .enable(enable), .latch(latch), .freq_bcd(freq_bcd), .ovf(ovf), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic bit [15:0] to_bcd(input int v);
    bit [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ovf_int = 0; m_ovf = 0; m_valid = 0; m_latch_d = 1; m_bcd = '0;
    for (int i = 0; i <= SYNC; i++) h[i] = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic cyc();
    bit e;
    @(posedge clk);
    if (reset) begin
      if (latch && !m_latch_d) begin
        m_bcd = to_bcd(m_cnt); m_ovf = m_ovf_int; m_valid = 1;
      end else m_valid = 0;
      m_latch_d = latch;
      e = h[SYNC-1] & ~h[SYNC];
      if (!clr_n) begin
        m_cnt = 0; m_ovf_int = 0;
      end else if (enable && e) begin
        if (m_cnt == MAXCNT) m_ovf_int = 1;
        else m_cnt++;
      end
      for (int i = SYNC; i > 0; i--) h[i] = h[i-1];
      h[0] = sig_in;
    end
    #1;
    chk("freq_bcd", 64'(freq_bcd), 64'(m_bcd));
    chk("ovf",      64'(ovf),      64'(m_ovf));
    chk("valid",    64'(valid),    64'(m_valid));
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  // n rising edges; hi/lo==0 picks a random 1..3 cycle phase length.
  task automatic rises(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      cycles(hi != 0 ? hi : int'($urandom_range(1, 3)));
      sig_in = 1'b0;
      cycles(lo != 0 ? lo : int'($urandom_range(1, 3)));
    end
  endtask

  task automatic do_clear();
    clr_n = 1'b0; cycles(2); clr_n = 1'b1;
  endtask

  task automatic do_latch(input string tag, input logic [15:0] exp_bcd, input logic exp_ovf);
    latch = 1'b0; cyc();
    latch = 1'b1; cyc();
    chk({tag, "_bcd"},   64'(freq_bcd), 64'(exp_bcd));
    chk({tag, "_ovf"},   64'(ovf),      64'(exp_ovf));
    chk({tag, "_valid"}, 64'(valid),    64'(1'b1));
    cyc();
    chk({tag, "_vdrop"}, 64'(valid),    64'(1'b0));
  endtask

  initial begin
    model_reset();
    // reset held with latch idle high
    #12;
    chk("rst_bcd", 64'(freq_bcd), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    #10 reset = 1'b1;
    cycles(50);
    chk("idle_bcd", 64'(freq_bcd), 64'(16'h0000));

    // 25 edges at period 4 inside a 100-cycle gate
    latch = 1'b0;
    do_clear();
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sig_in = ((i % 4) < 2);
      cyc();
    end
    enable = 1'b0; sig_in = 1'b0;
    cycles(4);
    latch = 1'b1; cyc();
    chk("p4_bcd", 64'(freq_bcd), 64'(16'h0025));
    chk("p4_valid", 64'(valid), 64'(1));
    cyc();
    chk("p4_vdrop", 64'(valid), 64'(0));

    // 1234 random-width edges: carries through three decades
    do_clear(); enable = 1'b1;
    rises(1234, 0, 0);
    cycles(4); enable = 1'b0;
    do_latch("c1234", 16'h1234, 1'b0);

    // overflow: 10005 edges saturate at 9999
    do_clear(); enable = 1'b1;
    rises(10005, 1, 1);
    cycles(4); enable = 1'b0;
    do_latch("sat", 16'h9999, 1'b1);
    chk("sat_nines", 64'(all_nines({{(BCD_W*MAX_DIGITS-16){1'b0}}, freq_bcd}, DIGITS)), 64'(1));
    do_clear();
    do_latch("satclr", 16'h0000, 1'b0);

    // edges with enable low are ignored
    do_clear(); enable = 1'b1;
    rises(7, 0, 0);
    cycles(4); enable = 1'b0;
    rises(20, 0, 0);
    cycles(4);
    do_latch("gated", 16'h0007, 1'b0);

    // edge coincident with clear: clear wins, edge discarded
    do_clear(); enable = 1'b1;
    rises(5, 0, 0);
    cycles(4);
    sig_in = 1'b1; cyc(); cyc();
    clr_n = 1'b0; cyc(); clr_n = 1'b1;
    sig_in = 1'b0; cycles(4);
    enable = 1'b0;
    do_latch("edgeclr", 16'h0000, 1'b0);

    // latch rise on the same edge as a counted edge
    do_clear(); enable = 1'b1;
    rises(41, 0, 0);
    cycles(4);
    latch = 1'b0; sig_in = 1'b1; cyc(); cyc();
    latch = 1'b1; cyc();
    chk("coin_bcd", 64'(freq_bcd), 64'(16'h0041));
    chk("coin_valid", 64'(valid), 64'(1));
    sig_in = 1'b0; cycles(4); enable = 1'b0;
    do_latch("coin_next", 16'h0042, 1'b0);

    // latch rise together with clear captures pre-clear count
    do_clear(); enable = 1'b1;
    rises(13, 0, 0);
    cycles(4); enable = 1'b0;
    latch = 1'b0; cyc();
    latch = 1'b1; clr_n = 1'b0; cyc(); clr_n = 1'b1;
    chk("latclr_bcd", 64'(freq_bcd), 64'(16'h0013));
    do_latch("latclr_after", 16'h0000, 1'b0);

    // asynchronous reset in the middle of a gate
    do_clear(); enable = 1'b1;
    rises(9, 0, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("mrst_bcd", 64'(freq_bcd), 64'(0));
    chk("mrst_ovf", 64'(ovf), 64'(0));
    chk("mrst_valid", 64'(valid), 64'(0));
    enable = 1'b0; sig_in = 1'b0; latch = 1'b1;
    cycles(3);
    #2 reset = 1'b1;
    cycles(2);
    latch = 1'b0;
    do_clear(); enable = 1'b1;
    rises(17, 0, 0);
    cycles(4); enable = 1'b0;
    do_latch("mrst_next", 16'h0017, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
